// File: rtl/sa_ram_fifo_ctrl_60x84.sv
// sa_ram_fifo_ctrl_60x84: ready/valid FIFO sequencer around a 60x84 two-stage-read RAM,
// with an empty-FIFO bypass and a credit-managed output buffer.
module sa_ram_fifo_ctrl_60x84 #(
   parameter int DEPTH      = 60,
   parameter int WIDTH      = 84,
   parameter int OBUF_DEPTH = 4,
   parameter bit BYPASS_EN  = 1'b1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    wr_valid,
   output logic                                    wr_ready,
   input  logic [WIDTH-1:0]                        wr_data,
   output logic                                    rd_valid,
   input  logic                                    rd_ready,
   output logic [WIDTH-1:0]                        rd_data,
   output logic [$clog2(DEPTH+OBUF_DEPTH+1)-1:0]   occupancy,
   output logic [$clog2(DEPTH)-1:0]                ram_ra,
   output logic                                    ram_re,
   output logic                                    ram_ore,
   input  logic [WIDTH-1:0]                        ram_dout,
   output logic [$clog2(DEPTH)-1:0]                ram_wa,
   output logic                                    ram_we,
   output logic [WIDTH-1:0]                        ram_di,
   output logic                                    ram_byp_sel,
   output logic [WIDTH-1:0]                        ram_dbyp,
   input  logic [31:0]                             pwrbus_in,
   output logic [31:0]                             ram_pwrbus_ram_pd
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int OW  = $clog2(OBUF_DEPTH + 1);
   localparam int OAW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int QW  = $clog2(DEPTH + OBUF_DEPTH + 1);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    ram_count;
   logic             s1_vld;
   logic             s1_byp;
   logic [WIDTH-1:0] s1_data;
   logic             s2_vld;
   logic [WIDTH-1:0] obuf [OBUF_DEPTH];
   logic [OAW-1:0]   ob_head;
   logic [OAW-1:0]   ob_tail;
   logic [OW-1:0]    obuf_count;

   logic [OW:0] used;
   logic        credit_ok;
   logic        byp_take;
   logic        ram_wr;
   logic        issue;
   logic        push;
   logic        pop;

   // Pointer wrap for the non-power-of-two RAM depth
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Pointer wrap for the output buffer ring
   function automatic logic [OAW-1:0] ob_inc(input logic [OAW-1:0] p);
      return (p == OAW'(OBUF_DEPTH - 1)) ? '0 : p + OAW'(1);
   endfunction

   // Credit, bypass and issue decisions from pre-pop state
   always_comb begin
      used      = {1'b0, obuf_count} + (OW+1)'(s1_vld) + (OW+1)'(s2_vld);
      credit_ok = used < (OW+1)'(OBUF_DEPTH);
      byp_take  = BYPASS_EN && wr_valid && !rst
                  && (ram_count == '0) && credit_ok;
      ram_wr    = wr_valid && !rst && !byp_take
                  && (ram_count < CW'(DEPTH));
      issue     = !rst && (ram_count != '0) && credit_ok && !byp_take;
      push      = s2_vld && !rst;
      pop       = rd_valid && rd_ready;
   end

   // RAM port drive and streaming outputs, forced idle while in reset
   always_comb begin
      wr_ready          = rst || (ram_count < CW'(DEPTH)) || byp_take;
      ram_we            = ram_wr;
      ram_wa            = ram_wr ? wr_ptr : '0;
      ram_di            = ram_wr ? wr_data : '0;
      ram_re            = issue;
      ram_ra            = issue ? rd_ptr : '0;
      ram_ore           = s1_vld && !rst;
      ram_byp_sel       = s1_vld && s1_byp && !rst;
      ram_dbyp          = ram_byp_sel ? s1_data : '0;
      rd_valid          = (obuf_count != '0) && !rst;
      rd_data           = rd_valid ? obuf[ob_head] : '0;
      occupancy         = rst ? '0 : QW'(ram_count) + QW'(s1_vld)
                          + QW'(s2_vld) + QW'(obuf_count);
      ram_pwrbus_ram_pd = pwrbus_in;
   end

   // Pointers, counts and read-pipeline valids
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ram_count  <= '0;
         s1_vld     <= 1'b0;
         s1_byp     <= 1'b0;
         s2_vld     <= 1'b0;
         ob_head    <= '0;
         ob_tail    <= '0;
         obuf_count <= '0;
      end else begin
         if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
         if (issue) rd_ptr <= ptr_inc(rd_ptr);
         unique case ({ram_wr, issue})
            2'b10:   ram_count <= ram_count + CW'(1);
            2'b01:   ram_count <= ram_count - CW'(1);
            default: ram_count <= ram_count;
         endcase
         s1_vld <= issue || byp_take;
         s1_byp <= byp_take;
         s2_vld <= s1_vld;
         if (push) ob_tail <= ob_inc(ob_tail);
         if (pop) ob_head <= ob_inc(ob_head);
         unique case ({push, pop})
            2'b10:   obuf_count <= obuf_count + OW'(1);
            2'b01:   obuf_count <= obuf_count - OW'(1);
            default: obuf_count <= obuf_count;
         endcase
      end
   end

   // Data capture for the bypass word and output buffer entries
   always_ff @(posedge clk) begin
      if (byp_take) s1_data <= wr_data;
      if (push) obuf[ob_tail] <= ram_dout;
   end

endmodule

// File: tb/tb_sa_ram_fifo_ctrl_60x84.sv
// tb_sa_ram_fifo_ctrl_60x84: directed and scoreboard bench with a behavioural
// two-stage-read RAM model attached to the controller's RAM ports.
module tb_sa_ram_fifo_ctrl_60x84;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [83:0] wr_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [83:0] rd_data;
   logic [6:0]  occupancy;
   logic [5:0]  ram_ra;
   logic        ram_re;
   logic        ram_ore;
   logic [83:0] ram_dout;
   logic [5:0]  ram_wa;
   logic        ram_we;
   logic [83:0] ram_di;
   logic        ram_byp_sel;
   logic [83:0] ram_dbyp;
   logic [31:0] pwrbus_in;
   logic [31:0] ram_pwrbus_ram_pd;

   sa_ram_fifo_ctrl_60x84 dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .occupancy(occupancy),
      .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
      .ram_dout(ram_dout),
      .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
      .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp),
      .pwrbus_in(pwrbus_in), .ram_pwrbus_ram_pd(ram_pwrbus_ram_pd)
   );

   always #5 clk = ~clk;

   // RAM model: re latches the address, ore loads the output register
   logic [83:0] mem [60];
   logic [5:0]  addr_q;
   logic [83:0] dout_q;
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) addr_q <= ram_ra;
      if (ram_ore) dout_q <= ram_byp_sel ? ram_dbyp : mem[addr_q];
   end
   assign ram_dout = dout_q;

   int checks = 0;
   int passes = 0;
   int pops = 0;
   logic [83:0] sb[$];

   task automatic check(input string tag, input logic [83:0] got,
                        input logic [83:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Record handshakes into the scoreboard, then advance one clock
   task automatic adv();
      if (!rst) begin
         if (wr_valid && wr_ready) sb.push_back(wr_data);
         if (rd_valid && rd_ready) begin
            pops++;
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else check("rd_data", rd_data, sb.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int re_cnt, sent, stalls, gaps, wwrap, rwrap, maxocc;
      logic [5:0] pwa, pra;
      rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      pwrbus_in = 32'h1234_5678;
      @(posedge clk); #1;
      @(posedge clk); #1;
      // reset state
      check("rst_wr_ready", wr_ready, 1);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_en", {ram_re, ram_ore, ram_we, ram_byp_sel}, 0);
      check("rst_addr", {ram_ra, ram_wa}, 0);
      check("rst_data", {ram_di, ram_dbyp, rd_data}, 0);
      check("pwrbus", ram_pwrbus_ram_pd, 32'h1234_5678);
      adv();
      rst = 1'b0;

      // T1: single write while idle goes through bypass
      rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 84'hA5; #1;
      check("t1_wr_ready", wr_ready, 1);
      check("t1_we", ram_we, 0);
      adv();
      wr_valid = 1'b0; #1;
      check("t1_byp_ore", {ram_byp_sel, ram_ore}, 2'b11);
      check("t1_dbyp", ram_dbyp, 84'hA5);
      check("t1_rv1", rd_valid, 0);
      check("t1_occ1", occupancy, 1);
      adv(); #1;
      check("t1_rv2", rd_valid, 0);
      check("t1_occ2", occupancy, 1);
      adv(); #1;
      check("t1_rv3", rd_valid, 1);
      check("t1_rd3", rd_data, 84'hA5);
      adv(); #1;
      check("t1_occ4", occupancy, 0);

      // T2: fill to full with the consumer stalled
      rd_ready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         wr_valid = 1'b1; wr_data = 84'(i); #1;
         check($sformatf("t2_wr_ready_%0d", i), wr_ready, 1);
         check($sformatf("t2_we_%0d", i), ram_we, (i >= 4));
         if (i >= 4) check($sformatf("t2_wa_%0d", i), ram_wa, i - 4);
         adv();
      end
      wr_data = 84'd64; #1;
      check("t2_full_ready", wr_ready, 0);
      check("t2_full_occ", occupancy, 64);
      check("t2_full_we", ram_we, 0);

      // T3: drain from full at one word per cycle
      wr_valid = 1'b0; rd_ready = 1'b1; pops = 0; re_cnt = 0;
      for (int c = 0; c < 70; c++) begin
         #1;
         if (c == 0) check("t3_re_c0", ram_re, 0);
         if (c == 1) begin
            check("t3_re_c1", ram_re, 1);
            check("t3_wr_ready_c1", wr_ready, 0);
         end
         if (c == 2) check("t3_wr_ready_c2", wr_ready, 1);
         if (c == 64) check("t3_pops_nogap", pops, 64);
         if (ram_re) re_cnt++;
         adv();
      end
      check("t3_pops", pops, 64);
      check("t3_re_cnt", re_cnt, 60);
      check("t3_occ", occupancy, 0);

      // T4: sustained stream of 200 words with pointer wrap
      pops = 0; sent = 0; stalls = 0; gaps = 0; wwrap = 0; rwrap = 0;
      pwa = '0; pra = '0;
      for (int c = 0; c < 260; c++) begin
         wr_valid = (sent < 200);
         wr_data = 84'(32'h1000 + sent);
         rd_ready = (c >= 10);
         #1;
         if (wr_valid && !wr_ready) stalls++;
         if (c >= 10 && c < 210 && !rd_valid) gaps++;
         if (ram_we) begin
            if (ram_wa == 6'd0 && pwa == 6'd59) wwrap++;
            pwa = ram_wa;
         end
         if (ram_re) begin
            if (ram_ra == 6'd0 && pra == 6'd59) rwrap++;
            pra = ram_ra;
         end
         if (wr_valid && wr_ready) sent++;
         adv();
      end
      check("t4_pops", pops, 200);
      check("t4_stalls", stalls, 0);
      check("t4_gaps", gaps, 0);
      check("t4_wwrap", wwrap, 3);
      check("t4_rwrap", rwrap, 3);
      check("t4_occ", occupancy, 0);

      // T5: random traffic against the scoreboard
      maxocc = 0;
      for (int c = 0; c < 400; c++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data = 84'({$urandom, $urandom, $urandom});
         rd_ready = 1'($urandom_range(0, 1));
         #1;
         check("t5_occ", occupancy, sb.size());
         if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
         adv();
      end
      check("t5_maxocc", (maxocc <= 64), 1);
      wr_valid = 1'b0; rd_ready = 1'b1;
      for (int c = 0; c < 80; c++) adv();
      #1;
      check("t5_drain_sb", sb.size(), 0);
      check("t5_drain_occ", occupancy, 0);

      // T6: reset with words in flight, then a clean bypass write
      rd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = 84'(32'h600 + i); #1;
         adv();
      end
      wr_valid = 1'b0; #1;
      check("t6_pre_occ", occupancy, 4);
      check("t6_pre_ore", ram_ore, 1);
      rst = 1'b1; #1;
      adv();
      sb.delete();
      rst = 1'b0; #1;
      check("t6_rv", rd_valid, 0);
      check("t6_occ", occupancy, 0);
      check("t6_re_ore", {ram_re, ram_ore}, 0);
      adv(); #1;
      adv();
      wr_valid = 1'b1; wr_data = 84'hDEAD_BEEF_0123; #1;
      check("t6_we", ram_we, 0);
      adv();
      wr_valid = 1'b0; #1;
      check("t6_byp_ore", {ram_byp_sel, ram_ore}, 2'b11);
      adv(); #1;
      adv(); #1;
      rd_ready = 1'b1;
      check("t6_rv3", rd_valid, 1);
      check("t6_rd3", rd_data, 84'hDEAD_BEEF_0123);
      adv(); #1;
      check("t6_occ_end", occupancy, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
